// File: rtl/vga_sync_receiver.sv
// VGA receive-side timing recovery: rebuilds pixel coordinates, data-enable
// and lock from sampled HS/VS/RGB, and flags line/frame timing errors.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic [7:0] i_rgb,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_de,
    output logic [7:0] o_rgb,
    output logic       o_frame_start,
    output logic       o_line_err,
    output logic       o_frame_err,
    output logic       o_locked
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HO      = H_SYNC + H_BP;
    localparam int unsigned VO      = V_SYNC + V_BP;
    localparam logic [9:0]  CNT_MAX = '1;
    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    logic [1:0]  rst_sync;
    logic        rst_sync_n;

    logic        primed;
    logic        hs_prev;
    logic        vs_prev;
    logic        seen_hs;
    logic        seen_vs;
    logic        frame_clean;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    lock_state_t state;
    logic [7:0]  good_cnt;

    logic        hs_a;
    logic        vs_a;
    logic        hs_fall;
    logic        hs_rise;
    logic        vs_fall;
    logic        vs_rise;
    logic [10:0] h_inc;
    logic [9:0]  h_next;
    logic [9:0]  v_line;
    logic [9:0]  v_next;
    logic [9:0]  x_next;
    logic [8:0]  y_next;
    logic        line_err;
    logic        frame_err;
    logic        any_err;
    logic        good_frame;
    logic        in_act;
    logic        de_next;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_sync_n = rst_sync[1];

    always_comb begin
        hs_a    = (i_hs == SYNC_POL);
        vs_a    = (i_vs == SYNC_POL);
        hs_fall = primed & hs_a & ~hs_prev;
        hs_rise = primed & ~hs_a & hs_prev;
        vs_fall = primed & vs_a & ~vs_prev;
        vs_rise = primed & ~vs_a & vs_prev;

        h_inc  = {1'b0, h_cnt} + 11'd1;
        h_next = hs_fall ? '0 : ((h_cnt == CNT_MAX) ? h_cnt : h_inc[9:0]);
        // VS edges coincide with the HS fall that opens a line, so the VS
        // checks use the line count including this sample's HS fall.
        v_line = (hs_fall && (v_cnt != CNT_MAX)) ? v_cnt + 10'd1 : v_cnt;
        v_next = vs_fall ? '0 : v_line;

        line_err  = (seen_hs & ((hs_rise & (h_inc != 11'(H_SYNC))) |
                                (hs_fall & (h_inc != 11'(H_TOTAL))))) |
                    (~hs_fall & (h_cnt == CNT_MAX - 10'd1));
        frame_err = seen_vs & ((vs_fall & (v_line != 10'(V_TOTAL))) |
                               (vs_rise & (v_line != 10'(V_SYNC))));
        any_err    = line_err | frame_err;
        good_frame = vs_fall & seen_vs & frame_clean & ~any_err;

        in_act = (h_next >= 10'(HO)) && (h_next <= 10'(HO + H_ACTIVE - 1)) &&
                 (v_next >= 10'(VO)) && (v_next <= 10'(VO + V_ACTIVE - 1));
        // Lock only rises at a VS fall (row 0, outside the window), so the
        // registered lock masked by this cycle's errors equals the next lock.
        de_next = in_act & o_locked & ~any_err;
        x_next  = h_next - 10'(HO);
        y_next  = 9'(v_next - 10'(VO));
    end

    // o_de and the three pulses are single-cycle qualifiers of a strobe.
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            primed        <= 1'b0;
            hs_prev       <= 1'b0;
            vs_prev       <= 1'b0;
            seen_hs       <= 1'b0;
            seen_vs       <= 1'b0;
            frame_clean   <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_rgb         <= '0;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_err    <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_err    <= 1'b0;
            o_frame_err   <= 1'b0;
            if (i_pix_stb) begin
                primed  <= 1'b1;
                hs_prev <= hs_a;
                vs_prev <= vs_a;
                if (hs_fall) seen_hs <= 1'b1;
                if (vs_fall) seen_vs <= 1'b1;
                if (vs_fall)      frame_clean <= 1'b1;
                else if (any_err) frame_clean <= 1'b0;
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                o_line_err  <= line_err;
                o_frame_err <= frame_err;
                if (de_next) begin
                    o_de          <= 1'b1;
                    o_x           <= x_next;
                    o_y           <= y_next;
                    o_rgb         <= i_rgb;
                    o_frame_start <= (x_next == '0) && (y_next == '0);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            o_locked <= 1'b0;
        end else if (i_pix_stb) begin
            if (any_err) begin
                state    <= UNLOCKED;
                good_cnt <= '0;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        if (good_frame) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt == LOCK_LAST) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED:  state <= LOCKED;
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomised-gap bench for vga_sync_receiver on a reduced raster, checked
// against an event-based reference model of the receive timing rules.
module tb_vga_sync_receiver;
    localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
    localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
    localparam int LOCKF = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int HO = HSW + HB;
    localparam int VO = VSW + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic       hs  = 1'b1;
    logic       vs  = 1'b1;
    logic [7:0] rgb = '0;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_de;
    logic [7:0] o_rgb;
    logic       o_frame_start;
    logic       o_line_err;
    logic       o_frame_err;
    logic       o_locked;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_hs(hs), .i_vs(vs), .i_rgb(rgb),
        .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_rgb(o_rgb), .o_frame_start(o_frame_start),
        .o_line_err(o_line_err), .o_frame_err(o_frame_err), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_de, n_fs, n_le, n_fe;

    // Reference model: positions are distances between sync events.
    int   idx, hfall_idx, lines, good;
    logic primed, ph, pv, seen_h, seen_v, clean, locked;
    int   ex_x, ex_y, ex_rgb;
    logic ex_de, ex_fs, ex_le, ex_fe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idx = 0; hfall_idx = -1; lines = 0; good = 0;
        primed = 0; ph = 0; pv = 0; seen_h = 0; seen_v = 0; clean = 0; locked = 0;
        ex_x = 0; ex_y = 0; ex_rgb = 0; ex_de = 0; ex_fs = 0; ex_le = 0; ex_fe = 0;
    endtask

    task automatic model(input logic h, input logic v, input logic [7:0] r);
        logic ha, va, hf, hr, vf, vr, gf;
        int   hpos, hcur, vcur;
        ha = (h == 1'b0); va = (v == 1'b0);
        hf = primed && ha && !ph;  hr = primed && !ha && ph;
        vf = primed && va && !pv;  vr = primed && !va && pv;
        hpos  = idx - hfall_idx;
        ex_le = (seen_h && hr && hpos != HSW) || (seen_h && hf && hpos != HT) || (!hf && hpos == 1023);
        if (hf) begin hfall_idx = idx; lines++; end
        ex_fe = (seen_v && vf && lines != VT) || (seen_v && vr && lines != VSW);
        gf = vf && seen_v && clean && !ex_le && !ex_fe;
        if (vf) lines = 0;
        if (ex_le || ex_fe) begin locked = 0; good = 0; end
        else if (gf) begin good++; if (good >= LOCKF) locked = 1; end
        if (vf) clean = 1; else if (ex_le || ex_fe) clean = 0;
        if (hf) seen_h = 1;
        if (vf) seen_v = 1;
        hcur = (idx - hfall_idx > 1023) ? 1023 : idx - hfall_idx;
        vcur = (lines > 1023) ? 1023 : lines;
        ex_de = locked && hcur >= HO && hcur < HO + HA && vcur >= VO && vcur < VO + VA;
        ex_fs = 0;
        if (ex_de) begin
            ex_x = hcur - HO; ex_y = vcur - VO; ex_rgb = int'(r);
            ex_fs = (ex_x == 0) && (ex_y == 0);
        end
        primed = 1; ph = ha; pv = va; idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); stb = 1'b0;
            @(posedge clk); #1;
            chk("idle_de", o_de, 0);
            chk("idle_err", o_line_err | o_frame_err, 0);
            chk("idle_x_hold", o_x, ex_x);
            chk("idle_locked", o_locked, locked);
        end
    endtask

    task automatic pix(input logic h, input logic v, input logic [7:0] r);
        idle(int'($urandom_range(2, 0)));
        @(negedge clk); stb = 1'b1; hs = h; vs = v; rgb = r;
        @(posedge clk); #1;
        model(h, v, r);
        chk("x", o_x, ex_x);
        chk("y", o_y, ex_y);
        chk("rgb", o_rgb, ex_rgb);
        chk("de", o_de, ex_de);
        chk("frame_start", o_frame_start, ex_fs);
        chk("line_err", o_line_err, ex_le);
        chk("frame_err", o_frame_err, ex_fe);
        chk("locked", o_locked, locked);
        n_de += int'(o_de); n_fs += int'(o_frame_start);
        n_le += int'(o_line_err); n_fe += int'(o_frame_err);
    endtask

    // Raster order per line: sync, back porch, active, front porch.
    task automatic frame(input int nlines, input int bad_line, input int bad_len,
                         input int bad_hsw, input int start, input int stop);
        int s, len, hw;
        logic [9:0] xv;
        logic [8:0] yv;
        logic [7:0] r;
        logic act;
        s = 0;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == bad_line) ? bad_len : HT;
            hw  = (ln == bad_line) ? bad_hsw : HSW;
            for (int p = 0; p < len; p++) begin
                if (s == stop) return;
                if (s >= start) begin
                    xv  = 10'(p - HO);
                    yv  = 9'(ln - VO);
                    act = (p >= HO) && (p < HO + HA) && (ln >= VO) && (ln < VO + VA);
                    r   = act ? {xv[1:0], yv[2:0], xv[4:2]} : 8'($urandom);
                    pix(p >= hw, ln >= VSW, r);
                    if (act && locked) begin
                        chk("pat_de", o_de, 1);
                        chk("pat_x", o_x, xv);
                        chk("pat_y", o_y, yv);
                        chk("pat_rgb", o_rgb, r);
                    end
                end
                s++;
            end
        end
    endtask

    task automatic nominal();
        frame(VT, -1, HT, HSW, 0, -1);
    endtask

    task automatic clear();
        n_de = 0; n_fs = 0; n_le = 0; n_fe = 0;
    endtask

    initial begin
        int s5, s6;
        s5 = (VO + 3) * HT + HO + 8;
        s6 = 7 * HT + 15;
        model_reset();
        clear();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", o_x, 0);            chk("rst_y", o_y, 0);
        chk("rst_rgb", o_rgb, 0);        chk("rst_de", o_de, 0);
        chk("rst_fs", o_frame_start, 0); chk("rst_le", o_line_err, 0);
        chk("rst_fe", o_frame_err, 0);   chk("rst_locked", o_locked, 0);
        @(negedge clk) rst = 1'b1;
        idle(3);

        // Nominal timing: lock at the second checked VS fall.
        for (int i = 0; i < 5; i++) pix(1'b1, 1'b1, 8'h00);
        nominal();
        nominal();
        chk("t1_unlocked_f2", o_locked, 0);
        n_de = 0; n_fs = 0;
        nominal();
        chk("t1_locked", o_locked, 1);
        chk("t1_de_count", n_de, HA * VA);
        chk("t1_fs_count", n_fs, 1);
        chk("t1_no_line_err", n_le, 0);
        chk("t1_no_frame_err", n_fe, 0);

        // Short line, then relock after two clean frames.
        clear();
        frame(VT, 7, HT - 1, HSW, 0, -1);
        chk("t3_line_err", n_le, 1);
        chk("t3_unlocked", o_locked, 0);
        nominal();
        nominal();
        chk("t3_still_unlocked", o_locked, 0);
        nominal();
        chk("t3_relocked", o_locked, 1);
        chk("t3_no_frame_err", n_fe, 0);

        // Short frame, then a narrow HS pulse.
        clear();
        frame(VT - 1, -1, HT, HSW, 0, -1);
        chk("t4_no_err_yet", n_fe + n_le, 0);
        frame(VT, 3, HT, HSW - 1, 0, -1);
        chk("t4_frame_err", n_fe, 1);
        chk("t4_hsw_line_err", n_le, 1);
        nominal();
        nominal();
        nominal();
        chk("t4_relocked", o_locked, 1);

        // Reset mid-line, resume mid-frame.
        frame(VT, -1, HT, HSW, 0, s5);
        @(negedge clk) stb = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t5_x", o_x, 0);             chk("t5_y", o_y, 0);
        chk("t5_rgb", o_rgb, 0);         chk("t5_de", o_de, 0);
        chk("t5_fs", o_frame_start, 0);  chk("t5_le", o_line_err, 0);
        chk("t5_fe", o_frame_err, 0);    chk("t5_locked", o_locked, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        idle(3);
        clear();
        frame(VT, -1, HT, HSW, s5 + 4, -1);
        nominal();
        nominal();
        nominal();
        chk("t5_no_line_err", n_le, 0);
        chk("t5_no_frame_err", n_fe, 0);
        chk("t5_relocked", o_locked, 1);

        // Strobe paused mid-line.
        clear();
        frame(VT, -1, HT, HSW, 0, s6);
        for (int i = 0; i < 10; i++) idle(100);
        frame(VT, -1, HT, HSW, s6, -1);
        nominal();
        chk("t6_no_err", n_le + n_fe, 0);
        chk("t6_locked", o_locked, 1);

        // Loss of HS: one saturation error only.
        clear();
        for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1, 8'($urandom));
        chk("sat_line_err_once", n_le, 1);
        chk("sat_unlocked", o_locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
